// File: rtl/rx_len_ctrl.sv
// Frame length sequencer for the rx path: counts bytes per valid 64-bit word between
// start-of-frame and end-of-frame, then reports the closed length and min/max length errors.
module rx_len_ctrl #(
    parameter int unsigned LEN_W     = 16,
    parameter int unsigned MIN_LEN   = 64,
    parameter int unsigned MAX_LEN   = 1518,
    parameter int unsigned JUMBO_LEN = 9018
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rx_valid,
    input  logic             rx_sof,
    input  logic             rx_eof,
    input  logic [2:0]       rx_eof_bytes,
    input  logic             jumbo_en,
    output logic [LEN_W-1:0] frame_len,
    output logic             len_valid,
    output logic             too_short,
    output logic             too_long,
    output logic             len_over,
    output logic             frame_abort
);

    typedef enum logic [1:0] {StIdle, StRecv, StOver} state_t;

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    // Set once the running count has clipped at all-ones; the true length is then unknown
    // but certainly larger than anything representable.
    logic               ovf_q, ovf_d;
    logic [31:0]        max_q, max_d;
    logic [LEN_W-1:0]   frame_len_q, frame_len_d;
    logic               len_valid_q, len_valid_d;
    logic               too_short_q, too_short_d;
    logic               too_long_q, too_long_d;
    logic               len_over_q, len_over_d;
    logic               frame_abort_q, frame_abort_d;

    // Arithmetic is one bit wider than the counter so a carry out means saturation.
    logic [LEN_W:0]     sum8;
    logic [LEN_W:0]     tail;
    logic [LEN_W:0]     sum_tail;
    logic [LEN_W-1:0]   cnt_plus8;
    logic               over8;
    logic               multi_ovf;
    logic [LEN_W-1:0]   multi_len;
    logic [LEN_W-1:0]   single_len;
    logic [31:0]        sof_max;

    // Datapath helpers: saturating adds and the limit selected by a start-of-frame beat.
    always_comb begin
        sum8       = {1'b0, cnt_q} + (LEN_W+1)'(8);
        cnt_plus8  = sum8[LEN_W] ? '1 : sum8[LEN_W-1:0];
        over8      = sum8[LEN_W] | (32'(sum8[LEN_W-1:0]) > max_q);
        tail       = (rx_eof_bytes == 3'd0) ? (LEN_W+1)'(8) : (LEN_W+1)'(rx_eof_bytes);
        sum_tail   = {1'b0, cnt_q} + tail;
        multi_ovf  = ovf_q | sum_tail[LEN_W];
        multi_len  = multi_ovf ? '1 : sum_tail[LEN_W-1:0];
        single_len = tail[LEN_W-1:0];
        sof_max    = jumbo_en ? JUMBO_LEN : MAX_LEN;
    end

    // Next-state and registered-output logic; idle cycles (rx_valid=0) hold everything.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        ovf_d         = ovf_q;
        max_d         = max_q;
        frame_len_d   = frame_len_q;
        len_valid_d   = 1'b0;
        too_short_d   = 1'b0;
        too_long_d    = 1'b0;
        len_over_d    = len_over_q;
        frame_abort_d = 1'b0;

        if (rx_valid) begin
            if (rx_sof) begin
                // A new sof inside a frame kills the old one without reporting its length.
                if (state_q != StIdle) begin
                    frame_abort_d = 1'b1;
                    len_over_d    = 1'b0;
                end
                max_d = sof_max;
                if (rx_eof) begin
                    frame_len_d = single_len;
                    len_valid_d = 1'b1;
                    too_long_d  = 32'(single_len) > sof_max;
                    too_short_d = !too_long_d && (32'(single_len) < MIN_LEN);
                    len_over_d  = 1'b0;
                    cnt_d       = '0;
                    ovf_d       = 1'b0;
                    state_d     = StIdle;
                end else begin
                    cnt_d   = LEN_W'(8);
                    ovf_d   = 1'b0;
                    state_d = StRecv;
                end
            end else if (state_q != StIdle) begin
                if (rx_eof) begin
                    frame_len_d = multi_len;
                    len_valid_d = 1'b1;
                    too_long_d  = multi_ovf || (32'(multi_len) > max_q);
                    too_short_d = !too_long_d && (32'(multi_len) < MIN_LEN);
                    len_over_d  = 1'b0;
                    cnt_d       = '0;
                    ovf_d       = 1'b0;
                    state_d     = StIdle;
                end else begin
                    cnt_d = cnt_plus8;
                    ovf_d = ovf_q | sum8[LEN_W];
                    if (state_q == StRecv && over8) begin
                        len_over_d = 1'b1;
                        state_d    = StOver;
                    end
                end
            end
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            ovf_q         <= 1'b0;
            max_q         <= MAX_LEN;
            frame_len_q   <= '0;
            len_valid_q   <= 1'b0;
            too_short_q   <= 1'b0;
            too_long_q    <= 1'b0;
            len_over_q    <= 1'b0;
            frame_abort_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            ovf_q         <= ovf_d;
            max_q         <= max_d;
            frame_len_q   <= frame_len_d;
            len_valid_q   <= len_valid_d;
            too_short_q   <= too_short_d;
            too_long_q    <= too_long_d;
            len_over_q    <= len_over_d;
            frame_abort_q <= frame_abort_d;
        end
    end

    assign frame_len   = frame_len_q;
    assign len_valid   = len_valid_q;
    assign too_short   = too_short_q;
    assign too_long    = too_long_q;
    assign len_over    = len_over_q;
    assign frame_abort = frame_abort_q;

endmodule

// File: tb/tb_rx_len_ctrl.sv
// Directed bench for rx_len_ctrl: a 16-bit and an 8-bit (saturating) instance share stimulus;
// expected closes are queued per frame and compared when len_valid fires.
module tb_rx_len_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx_valid, rx_sof, rx_eof, jumbo_en;
    logic [2:0]  rx_eof_bytes;
    logic [15:0] frame_len;
    logic        len_valid, too_short, too_long, len_over, frame_abort;
    logic [7:0]  frame_len8;
    logic        len_valid8, too_short8, too_long8, len_over8, frame_abort8;

    int n_checks = 0;
    int n_fail   = 0;
    int abort_seen = 0;

    typedef struct {
        int len;
        bit sh;
        bit lg;
        int len8;
        bit sh8;
        bit lg8;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    rx_len_ctrl #(.LEN_W(16)) dut (
        .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_sof(rx_sof), .rx_eof(rx_eof),
        .rx_eof_bytes(rx_eof_bytes), .jumbo_en(jumbo_en), .frame_len(frame_len),
        .len_valid(len_valid), .too_short(too_short), .too_long(too_long),
        .len_over(len_over), .frame_abort(frame_abort)
    );

    rx_len_ctrl #(.LEN_W(8)) dut8 (
        .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_sof(rx_sof), .rx_eof(rx_eof),
        .rx_eof_bytes(rx_eof_bytes), .jumbo_en(jumbo_en), .frame_len(frame_len8),
        .len_valid(len_valid8), .too_short(too_short8), .too_long(too_long8),
        .len_over(len_over8), .frame_abort(frame_abort8)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic s, input logic e, input logic [2:0] b);
        rx_valid = v;
        rx_sof = s;
        rx_eof = e;
        rx_eof_bytes = b;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_frame(input int len, input int maxl);
        exp_t e;
        e.len  = len;
        e.lg   = len > maxl;
        e.sh   = !e.lg && len < 64;
        e.len8 = (len > 255) ? 255 : len;
        e.lg8  = (len > 255) || (len > maxl);
        e.sh8  = !e.lg8 && len < 64;
        sb.push_back(e);
    endtask

    // Sends a whole frame, optionally with idle gaps and a mid-frame jumbo_en flip.
    task automatic send_frame(input int nwords, input int bytes, input int gap, input bit flip);
        int tail;
        int len;
        tail = (bytes == 0) ? 8 : bytes;
        len = (nwords == 1) ? tail : (nwords - 1) * 8 + tail;
        expect_frame(len, jumbo_en ? 9018 : 1518);
        if (nwords == 1) begin
            drive(1'b1, 1'b1, 1'b1, 3'(bytes));
        end else begin
            drive(1'b1, 1'b1, 1'b0, 3'd0);
            if (flip) jumbo_en = ~jumbo_en;
            for (int i = 0; i < nwords - 2; i++) begin
                repeat (gap) drive(1'b0, 1'b0, 1'b0, 3'd0);
                drive(1'b1, 1'b0, 1'b0, 3'd0);
            end
            repeat (gap) drive(1'b0, 1'b0, 1'b0, 3'd0);
            drive(1'b1, 1'b0, 1'b1, 3'(bytes));
        end
        check("len_valid_latency", 32'(len_valid), 32'd1);
        rx_valid = 1'b0;
        rx_sof = 1'b0;
        rx_eof = 1'b0;
    endtask

    // Scoreboard side: compare each close against the oldest queued expectation.
    always @(negedge clk) begin
        if (reset && frame_abort) abort_seen++;
        if (reset && len_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_len_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("frame_len", 32'(frame_len), 32'(e.len));
                check("too_short", 32'(too_short), 32'(e.sh));
                check("too_long", 32'(too_long), 32'(e.lg));
                check("len_valid8", 32'(len_valid8), 32'd1);
                check("frame_len8", 32'(frame_len8), 32'(e.len8));
                check("too_short8", 32'(too_short8), 32'(e.sh8));
                check("too_long8", 32'(too_long8), 32'(e.lg8));
            end
        end
    end

    initial begin
        reset = 1'b0;
        rx_valid = 1'b0;
        rx_sof = 1'b0;
        rx_eof = 1'b0;
        rx_eof_bytes = 3'd0;
        jumbo_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_frame_len", 32'(frame_len), 32'd0);
        check("rst_len_valid", 32'(len_valid), 32'd0);
        check("rst_too_short", 32'(too_short), 32'd0);
        check("rst_too_long", 32'(too_long), 32'd0);
        check("rst_len_over", 32'(len_over), 32'd0);
        check("rst_frame_abort", 32'(frame_abort), 32'd0);
        check("rst_frame_len8", 32'(frame_len8), 32'd0);
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 3'd0);

        // Basic 68-byte frame, single-word frame, 60-byte runt.
        send_frame(9, 4, 0, 1'b0);
        send_frame(1, 0, 0, 1'b0);
        send_frame(8, 4, 0, 1'b0);

        // 1520-byte frame: too long normally, legal when jumbo was set at sof.
        send_frame(190, 0, 0, 1'b1);
        jumbo_en = 1'b1;
        send_frame(190, 0, 0, 1'b1);
        jumbo_en = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 3'd0);

        // Running overflow flag on a 1600-byte frame.
        expect_frame(1600, 1518);
        drive(1'b1, 1'b1, 1'b0, 3'd0);
        for (int i = 2; i < 200; i++) begin
            drive(1'b1, 1'b0, 1'b0, 3'd0);
            if (i == 189) check("len_over_at_1512", 32'(len_over), 32'd0);
            if (i == 190) check("len_over_at_1520", 32'(len_over), 32'd1);
        end
        check("len_over_held", 32'(len_over), 32'd1);
        drive(1'b1, 1'b0, 1'b1, 3'd0);
        check("len_over_cleared", 32'(len_over), 32'd0);
        check("len_valid_long", 32'(len_valid), 32'd1);
        drive(1'b0, 1'b0, 1'b0, 3'd0);

        // Abort: sof, 3 words, then a new sof starting a 72-byte frame.
        drive(1'b1, 1'b1, 1'b0, 3'd0);
        repeat (3) drive(1'b1, 1'b0, 1'b0, 3'd0);
        expect_frame(72, 1518);
        drive(1'b1, 1'b1, 1'b0, 3'd0);
        check("frame_abort_pulse", 32'(frame_abort), 32'd1);
        check("no_len_valid_on_abort", 32'(len_valid), 32'd0);
        repeat (7) drive(1'b1, 1'b0, 1'b0, 3'd0);
        check("frame_abort_single", 32'(frame_abort), 32'd0);
        drive(1'b1, 1'b0, 1'b1, 3'd0);
        check("len_valid_after_abort", 32'(len_valid), 32'd1);
        drive(1'b0, 1'b0, 1'b0, 3'd0);

        // Gapped 12-word frame, then back-to-back frames at line rate.
        send_frame(12, 3, 2, 1'b0);
        send_frame(8, 0, 0, 1'b0);
        send_frame(10, 5, 0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 3'd0);

        // Reset mid-frame discards it; the following clean frame is unaffected.
        drive(1'b1, 1'b1, 1'b0, 3'd0);
        repeat (3) drive(1'b1, 1'b0, 1'b0, 3'd0);
        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 3'd0);
        check("midrst_frame_len", 32'(frame_len), 32'd0);
        check("midrst_len_over", 32'(len_over), 32'd0);
        reset = 1'b1;
        send_frame(8, 0, 0, 1'b0);

        for (int i = 0; i < 20 && sb.size() != 0; i++) drive(1'b0, 1'b0, 1'b0, 3'd0);
        repeat (3) drive(1'b0, 1'b0, 1'b0, 3'd0);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        check("abort_count", 32'(abort_seen), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
